// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and small helpers for the PS/2 keyboard
// sequencer and its scan-code FIFO.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [3:0] {
    ST_START,
    ST_RST_TX,
    ST_RST_ACK,
    ST_RST_BAT,
    ST_IDLE,
    ST_LED_CMD_TX,
    ST_LED_CMD_ACK,
    ST_LED_VAL_TX,
    ST_LED_VAL_ACK,
    ST_FAIL
  } kbd_state_e;

  function automatic logic [31:0] ms_to_cycles(input int clk_mhz, input int ms);
    return 32'(clk_mhz * 1000 * ms);
  endfunction

  function automatic logic is_tx_state(input kbd_state_e s);
    return s inside {ST_RST_TX, ST_LED_CMD_TX, ST_LED_VAL_TX};
  endfunction

  function automatic logic is_led_state(input kbd_state_e s);
    return s inside {ST_LED_CMD_TX, ST_LED_CMD_ACK, ST_LED_VAL_TX, ST_LED_VAL_ACK};
  endfunction

  // Transmit state that (re)sends the byte a given state is working on.
  function automatic kbd_state_e tx_state_of(input kbd_state_e s);
    case (s)
      ST_LED_CMD_TX, ST_LED_CMD_ACK: return ST_LED_CMD_TX;
      ST_LED_VAL_TX, ST_LED_VAL_ACK: return ST_LED_VAL_TX;
      default:                       return ST_RST_TX;
    endcase
  endfunction

  function automatic kbd_state_e ack_state_of(input kbd_state_e s);
    case (s)
      ST_LED_CMD_TX: return ST_LED_CMD_ACK;
      ST_LED_VAL_TX: return ST_LED_VAL_ACK;
      default:       return ST_RST_ACK;
    endcase
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Synchronous show-ahead FIFO for keyboard scan codes. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module ps2_code_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  import ps2_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Keyboard sequencer in front of ps2_host: reset/BAT handshake, scan-code
// buffering and LED updates with resend, timeout and retry handling.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ       = 100,
  parameter int ACK_TIMEOUT_MS = 20,
  parameter int BAT_TIMEOUT_MS = 1000,
  parameter int MAX_RETRY      = 3,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reinit,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       led_busy,
  output logic       led_err,
  output logic       ready,
  output logic       init_err,
  output logic       code_valid,
  output logic [7:0] code_data,
  input  logic       code_rd,
  output logic       overflow,
  output logic       rx_err_flag,
  output logic       h_tx_en,
  output logic [7:0] h_tx_data,
  output logic       h_rx_en,
  input  logic [7:0] h_rx_data,
  input  logic       h_tx_ack,
  input  logic       h_tx_err,
  input  logic       h_rx_ack,
  input  logic       h_rx_err,
  input  logic       h_rx_busy
);

  localparam logic [31:0] ACK_TICKS = ms_to_cycles(CLK_FREQ, ACK_TIMEOUT_MS);
  localparam logic [31:0] BAT_TICKS = ms_to_cycles(CLK_FREQ, BAT_TIMEOUT_MS);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  kbd_state_e         state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [31:0]        timer_q, timer_d;
  logic               ready_q, ready_d;
  logic               init_err_q, init_err_d;
  logic               led_err_q, led_err_d;
  logic               pending_q, pending_d;
  logic [2:0]         led_val_q, led_val_d;
  logic [2:0]         led_cur_q, led_cur_d;
  logic               rx_err_q, rx_err_d;
  logic               overflow_q, overflow_d;
  logic               h_tx_en_q, h_tx_en_d;
  logic [7:0]         h_tx_data_q, h_tx_data_d;
  logic               h_rx_en_q, h_rx_en_d;

  logic        fifo_push;
  logic        fifo_clear;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tx_abort;
  logic        retry_evt;
  logic        do_reinit;
  logic [31:0] wait_limit;
  logic        timeout;

  // code_valid/code_rd: code_data holds the oldest byte while code_valid is
  // high; a cycle with code_rd high consumes it, and code_rd while empty is ignored.
  ps2_code_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (h_rx_data),
    .pop       (code_rd),
    .head      (code_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wait_limit = (state_q == ST_RST_BAT) ? BAT_TICKS : ACK_TICKS;
  // >= so that a timeout coinciding with a buffered scan code fires a cycle later.
  assign timeout    = (timer_q >= (wait_limit - 32'd1));

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    ready_d    = ready_q;
    init_err_d = init_err_q;
    led_err_d  = 1'b0;
    pending_d  = pending_q;
    led_val_d  = led_val_q;
    led_cur_d  = led_cur_q;
    rx_err_d   = rx_err_q | h_rx_err;
    overflow_d = overflow_q;
    fifo_push  = 1'b0;
    fifo_clear = 1'b0;
    tx_abort   = 1'b0;
    retry_evt  = 1'b0;
    do_reinit  = 1'b0;

    if (led_req) begin
      pending_d = 1'b1;
      led_val_d = led_val;
    end

    case (state_q)
      ST_START: begin
        state_d = ST_RST_TX;
        retry_d = '0;
      end
      ST_RST_TX, ST_LED_CMD_TX, ST_LED_VAL_TX: begin
        if (h_tx_ack) begin
          state_d = ack_state_of(state_q);
        end else if (h_tx_err) begin
          retry_evt = 1'b1;
          tx_abort  = 1'b1;
        end
      end
      ST_RST_ACK, ST_LED_CMD_ACK, ST_LED_VAL_ACK: begin
        if (h_rx_ack && h_rx_data == RSP_ACK) begin
          case (state_q)
            ST_RST_ACK:     state_d = ST_RST_BAT;
            ST_LED_CMD_ACK: begin
              state_d = ST_LED_VAL_TX;
              retry_d = '0;
            end
            default:        state_d = ST_IDLE;
          endcase
        end else if (h_rx_ack && h_rx_data == RSP_RESEND) begin
          retry_evt = 1'b1;
        end else if (h_rx_ack) begin
          fifo_push = 1'b1;
        end else if (timeout) begin
          retry_evt = 1'b1;
        end
      end
      ST_RST_BAT: begin
        if (h_rx_ack && h_rx_data == RSP_BAT_OK) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else if (h_rx_ack && (h_rx_data == RSP_BAT_FAIL || h_rx_data == RSP_RESEND)) begin
          retry_evt = 1'b1;
        end else if (h_rx_ack) begin
          fifo_push = 1'b1;
        end else if (timeout) begin
          retry_evt = 1'b1;
        end
      end
      ST_IDLE: begin
        if (h_rx_ack) fifo_push = 1'b1;
        if (reinit) begin
          do_reinit = 1'b1;
        end else if (pending_q && !h_rx_busy && !h_rx_ack) begin
          state_d   = ST_LED_CMD_TX;
          retry_d   = '0;
          pending_d = led_req;
          led_cur_d = led_val_q;
        end
      end
      ST_FAIL: begin
        if (reinit) do_reinit = 1'b1;
      end
      default: state_d = ST_START;
    endcase

    if (retry_evt) begin
      if (retry_q == RETRY_MAX) begin
        if (is_led_state(state_q)) begin
          state_d   = ST_IDLE;
          led_err_d = 1'b1;
        end else begin
          state_d    = ST_FAIL;
          init_err_d = 1'b1;
          ready_d    = 1'b0;
        end
      end else begin
        retry_d = retry_q + RETRY_ONE;
        state_d = tx_state_of(state_q);
      end
    end

    if (fifo_push && fifo_full && !code_rd) overflow_d = 1'b1;

    if (do_reinit) begin
      state_d    = ST_RST_TX;
      retry_d    = '0;
      ready_d    = 1'b0;
      init_err_d = 1'b0;
      fifo_clear = 1'b1;
      overflow_d = 1'b0;
      rx_err_d   = 1'b0;
      pending_d  = 1'b0;
    end

    // Outputs are registered from the next state; a transmit error drops
    // h_tx_en for one cycle so ps2_host sees a fresh request on the resend.
    h_tx_en_d = is_tx_state(state_d) && !tx_abort;
    case (state_d)
      ST_RST_TX:     h_tx_data_d = CMD_RESET;
      ST_LED_CMD_TX: h_tx_data_d = CMD_SET_LED;
      ST_LED_VAL_TX: h_tx_data_d = {5'b0, led_cur_d};
      default:       h_tx_data_d = 8'h00;
    endcase
    h_rx_en_d = !(is_tx_state(state_d) || state_d == ST_START || state_d == ST_FAIL);
    timer_d   = (state_d != state_q) ? 32'd0 : timer_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_START;
      retry_q     <= '0;
      timer_q     <= '0;
      ready_q     <= 1'b0;
      init_err_q  <= 1'b0;
      led_err_q   <= 1'b0;
      pending_q   <= 1'b0;
      led_val_q   <= '0;
      led_cur_q   <= '0;
      rx_err_q    <= 1'b0;
      overflow_q  <= 1'b0;
      h_tx_en_q   <= 1'b0;
      h_tx_data_q <= 8'h00;
      h_rx_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      ready_q     <= ready_d;
      init_err_q  <= init_err_d;
      led_err_q   <= led_err_d;
      pending_q   <= pending_d;
      led_val_q   <= led_val_d;
      led_cur_q   <= led_cur_d;
      rx_err_q    <= rx_err_d;
      overflow_q  <= overflow_d;
      h_tx_en_q   <= h_tx_en_d;
      h_tx_data_q <= h_tx_data_d;
      h_rx_en_q   <= h_rx_en_d;
    end
  end

  assign led_busy    = pending_q || is_led_state(state_q);
  assign led_err     = led_err_q;
  assign ready       = ready_q;
  assign init_err    = init_err_q;
  assign code_valid  = !fifo_empty;
  assign overflow    = overflow_q;
  assign rx_err_flag = rx_err_q;
  assign h_tx_en     = h_tx_en_q;
  assign h_tx_data   = h_tx_data_q;
  assign h_rx_en     = h_rx_en_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a keyboard/host model answers transmits,
// expected transmitted bytes and scan codes are queued and checked in order.
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       reinit;
  logic       led_req;
  logic [2:0] led_val;
  logic       led_busy;
  logic       led_err;
  logic       ready;
  logic       init_err;
  logic       code_valid;
  logic [7:0] code_data;
  logic       code_rd;
  logic       overflow;
  logic       rx_err_flag;
  logic       h_tx_en;
  logic [7:0] h_tx_data;
  logic       h_rx_en;
  logic [7:0] h_rx_data;
  logic       h_tx_ack;
  logic       h_tx_err;
  logic       h_rx_ack;
  logic       h_rx_err;
  logic       h_rx_busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  ps2_kbd_ctrl #(
    .CLK_FREQ       (1),
    .ACK_TIMEOUT_MS (1),
    .BAT_TIMEOUT_MS (2),
    .MAX_RETRY      (3),
    .FIFO_DEPTH     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reinit      (reinit),
    .led_req     (led_req),
    .led_val     (led_val),
    .led_busy    (led_busy),
    .led_err     (led_err),
    .ready       (ready),
    .init_err    (init_err),
    .code_valid  (code_valid),
    .code_data   (code_data),
    .code_rd     (code_rd),
    .overflow    (overflow),
    .rx_err_flag (rx_err_flag),
    .h_tx_en     (h_tx_en),
    .h_tx_data   (h_tx_data),
    .h_rx_en     (h_rx_en),
    .h_rx_data   (h_rx_data),
    .h_tx_ack    (h_tx_ack),
    .h_tx_err    (h_tx_err),
    .h_rx_ack    (h_rx_ack),
    .h_rx_err    (h_rx_err),
    .h_rx_busy   (h_rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait for the next transmit request, compare it with the queued byte and
  // optionally answer it with h_tx_ack.
  task automatic tx_byte(input string tag, input bit ack);
    int n;
    logic [7:0] exp_b;
    n = 0;
    while (h_tx_en !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_txen"}, 32'(h_tx_en), 32'd1);
    chk({tag, "_txq"}, 32'(tx_q.size() > 0), 32'd1);
    exp_b = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
    chk({tag, "_txdata"}, 32'(h_tx_data), 32'(exp_b));
    if (ack) begin
      h_tx_ack = 1'b1;
      @(negedge clk);
      h_tx_ack = 1'b0;
      chk({tag, "_txdrop"}, 32'(h_tx_en), 32'd0);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit to_fifo);
    h_rx_data = b;
    h_rx_ack  = 1'b1;
    if (to_fifo) exp_q.push_back(b);
    @(negedge clk);
    h_rx_ack  = 1'b0;
  endtask

  task automatic pop_code(input string tag);
    int n;
    logic [7:0] exp_b;
    n = 0;
    while (code_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(code_valid), 32'd1);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    chk({tag, "_data"}, 32'(code_data), 32'(exp_b));
    code_rd = 1'b1;
    @(negedge clk);
    code_rd = 1'b0;
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] r;
    rst = 1'b1; reinit = 1'b0; led_req = 1'b0; led_val = 3'b000; code_rd = 1'b0;
    h_rx_data = 8'h00; h_tx_ack = 1'b0; h_tx_err = 1'b0; h_rx_ack = 1'b0;
    h_rx_err = 1'b0; h_rx_busy = 1'b0;
    cyc(3);

    // Reset values
    chk("rst_txen", 32'(h_tx_en), 32'd0);
    chk("rst_rxen", 32'(h_rx_en), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_initerr", 32'(init_err), 32'd0);
    chk("rst_valid", 32'(code_valid), 32'd0);
    chk("rst_data", 32'(code_data), 32'd0);
    chk("rst_busy", 32'(led_busy), 32'd0);
    chk("rst_lederr", 32'(led_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rxerr", 32'(rx_err_flag), 32'd0);

    // Init: 0xFF -> 0xFA -> 0xAA
    rst = 1'b0;
    tx_q.push_back(8'hFF);
    chk("start_txen", 32'(h_tx_en), 32'd0);
    @(negedge clk);
    chk("start2_txen", 32'(h_tx_en), 32'd1);
    tx_byte("init", 1'b1);
    chk("init_rxen", 32'(h_rx_en), 32'd1);
    send_rx(8'hFA, 1'b0);
    chk("init_notready", 32'(ready), 32'd0);
    send_rx(8'hAA, 1'b0);
    chk("init_ready", 32'(ready), 32'd1);
    chk("init_err0", 32'(init_err), 32'd0);
    chk("init_empty", 32'(code_valid), 32'd0);
    chk("init_idle_tx", 32'(h_tx_en), 32'd0);

    // Scan-code stream
    send_rx(8'h1C, 1'b1);
    chk("stream_valid_n1", 32'(code_valid), 32'd1);
    send_rx(8'hF0, 1'b1);
    send_rx(8'h1C, 1'b1);
    pop_code("stream0");
    pop_code("stream1");
    pop_code("stream2");
    chk("stream_empty", 32'(code_valid), 32'd0);
    code_rd = 1'b1;
    @(negedge clk);
    code_rd = 1'b0;
    chk("pop_empty_valid", 32'(code_valid), 32'd0);
    chk("pop_empty_data", 32'(code_data), 32'd0);

    // Receive error is flagged, byte discarded
    h_rx_err = 1'b1;
    @(negedge clk);
    h_rx_err = 1'b0;
    chk("rxerr_flag", 32'(rx_err_flag), 32'd1);
    chk("rxerr_nopush", 32'(code_valid), 32'd0);

    // Fill, simultaneous push/pop when full, then overflow
    for (int i = 0; i < 8; i++) send_rx(8'($urandom_range(0, 255)), 1'b1);
    chk("full_noovf", 32'(overflow), 32'd0);
    r = 8'($urandom_range(0, 255));
    h_rx_data = r;
    h_rx_ack  = 1'b1;
    code_rd   = 1'b1;
    chk("fullpp_head", 32'(code_data), 32'(exp_q.pop_front()));
    exp_q.push_back(r);
    @(negedge clk);
    h_rx_ack = 1'b0;
    code_rd  = 1'b0;
    chk("fullpp_noovf", 32'(overflow), 32'd0);
    send_rx(8'($urandom_range(0, 255)), 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) pop_code($sformatf("ovf_pop%0d", i));
    chk("ovf_empty", 32'(code_valid), 32'd0);

    // LED update with a scan code mid-handshake and a second request queued
    led_val = 3'b101;
    led_req = 1'b1;
    tx_q.push_back(8'hED);
    tx_q.push_back(8'h05);
    @(negedge clk);
    led_req = 1'b0;
    chk("led1_busy", 32'(led_busy), 32'd1);
    tx_byte("led1_cmd", 1'b1);
    send_rx(8'h1C, 1'b1);
    chk("led_scan_valid", 32'(code_valid), 32'd1);
    led_val = 3'b010;
    led_req = 1'b1;
    tx_q.push_back(8'hED);
    tx_q.push_back(8'h02);
    @(negedge clk);
    led_req = 1'b0;
    send_rx(8'hFA, 1'b0);
    tx_byte("led1_val", 1'b1);
    send_rx(8'hFA, 1'b0);
    chk("led2_pending", 32'(led_busy), 32'd1);
    tx_byte("led2_cmd", 1'b1);
    send_rx(8'hFA, 1'b0);
    tx_byte("led2_val", 1'b1);
    send_rx(8'hFE, 1'b0);
    tx_q.push_back(8'h02);
    tx_byte("led2_resend", 1'b1);
    send_rx(8'hFA, 1'b0);
    chk("led_done_busy", 32'(led_busy), 32'd0);
    chk("led_done_tx", 32'(h_tx_en), 32'd0);
    chk("led_done_err", 32'(led_err), 32'd0);
    pop_code("led_scan");

    // LED update with no response: abandoned after MAX_RETRY resends
    led_val = 3'b111;
    led_req = 1'b1;
    for (int i = 0; i < 4; i++) tx_q.push_back(8'hED);
    @(negedge clk);
    led_req = 1'b0;
    for (int i = 0; i < 4; i++) tx_byte($sformatf("ledto%0d", i), 1'b1);
    n = 0;
    while (led_err !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ledto_err", 32'(led_err), 32'd1);
    chk("ledto_busy", 32'(led_busy), 32'd0);
    @(negedge clk);
    chk("ledto_pulse", 32'(led_err), 32'd0);
    chk("ledto_ready", 32'(ready), 32'd1);
    chk("ledto_notx", 32'(h_tx_en), 32'd0);

    // Reinit clears state; init with one resend
    send_rx(8'h55, 1'b0);
    chk("pre_reinit_valid", 32'(code_valid), 32'd1);
    tx_q.push_back(8'hFF);
    pulse_reinit();
    chk("reinit_ready", 32'(ready), 32'd0);
    chk("reinit_ovf", 32'(overflow), 32'd0);
    chk("reinit_rxerr", 32'(rx_err_flag), 32'd0);
    chk("reinit_fifo", 32'(code_valid), 32'd0);
    tx_byte("resend0", 1'b1);
    send_rx(8'hFE, 1'b0);
    tx_q.push_back(8'hFF);
    tx_byte("resend1", 1'b1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    chk("resend_ready", 32'(ready), 32'd1);
    cyc(5);
    chk("resend_no3rd", 32'(h_tx_en), 32'd0);

    // Init timeout: four 0xFF transmissions, then FAIL
    for (int i = 0; i < 4; i++) tx_q.push_back(8'hFF);
    pulse_reinit();
    for (int i = 0; i < 4; i++) tx_byte($sformatf("initto%0d", i), 1'b1);
    n = 0;
    while (init_err !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("initto_err", 32'(init_err), 32'd1);
    chk("initto_ready", 32'(ready), 32'd0);
    chk("initto_rxen", 32'(h_rx_en), 32'd0);
    cyc(5);
    chk("initto_no5th", 32'(h_tx_en), 32'd0);
    chk("initto_held", 32'(init_err), 32'd1);

    // Reinit from FAIL, with a BAT failure forcing a full reset retry
    tx_q.push_back(8'hFF);
    pulse_reinit();
    chk("refail_err", 32'(init_err), 32'd0);
    tx_byte("bat0", 1'b1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hFC, 1'b0);
    tx_q.push_back(8'hFF);
    tx_byte("bat1", 1'b1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    chk("bat_ready", 32'(ready), 32'd1);

    // rst during LED_VAL_TX: pending request lost, init restarts
    led_val = 3'b011;
    led_req = 1'b1;
    tx_q.push_back(8'hED);
    tx_q.push_back(8'h03);
    @(negedge clk);
    led_req = 1'b0;
    tx_byte("rstled_cmd", 1'b1);
    send_rx(8'hFA, 1'b0);
    tx_byte("rstled_val", 1'b0);
    led_val = 3'b110;
    led_req = 1'b1;
    @(negedge clk);
    led_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_txen", 32'(h_tx_en), 32'd0);
    chk("midrst_busy", 32'(led_busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rxen", 32'(h_rx_en), 32'd0);
    rst = 1'b0;
    tx_q.push_back(8'hFF);
    @(negedge clk);
    chk("postrst_txen", 32'(h_tx_en), 32'd1);
    tx_byte("postrst", 1'b1);
    send_rx(8'hFA, 1'b0);
    send_rx(8'hAA, 1'b0);
    chk("postrst_ready", 32'(ready), 32'd1);
    cyc(5);
    chk("postrst_busy", 32'(led_busy), 32'd0);
    chk("postrst_notx", 32'(h_tx_en), 32'd0);
    chk("txq_drained", 32'(tx_q.size()), 32'd0);
    chk("expq_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
